// File: rtl/icache.sv
// Direct-mapped instruction cache, one 32-bit word per line, with a single
// outstanding refill toward the memory controller and redirect abandonment.
module icache #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        if_valid,
   input  logic [31:0] if_addr,
   output logic        if_ready,
   output logic [31:0] if_inst,
   input  logic        clear,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_data,
   input  logic        mem_done
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic {IDLE, MISS} state_t;

   state_t                  state;
   logic [31:2]             req_addr;
   logic [LINES-1:0]        valid;
   logic [TAG_W-1:0]        tags [LINES];
   logic [31:0]             data [LINES];

   logic [INDEX_BITS-1:0]   if_idx;
   logic [TAG_W-1:0]        if_tag;
   logic [INDEX_BITS-1:0]   req_idx;
   logic [TAG_W-1:0]        req_tag;
   logic                    hit;
   logic                    accept;
   logic                    fill;
   logic                    unused_bits;

   assign if_idx      = if_addr[INDEX_BITS+1:2];
   assign if_tag      = if_addr[31:INDEX_BITS+2];
   assign req_idx     = req_addr[INDEX_BITS+1:2];
   assign req_tag     = req_addr[31:INDEX_BITS+2];
   assign hit         = valid[if_idx] && (tags[if_idx] == if_tag);
   assign accept      = rdy && (state == IDLE) && if_valid && !clear;
   assign fill        = rdy && (state == MISS) && mem_done && !clear;
   assign unused_bits = ^if_addr[1:0];

   // Tag/data storage and the latched request carry no reset; valid bits guard them.
   always_ff @(posedge clk) begin
      if (accept)
         req_addr <= if_addr[31:2];
      if (fill) begin
         data[req_idx] <= mem_data;
         tags[req_idx] <= req_tag;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         valid    <= '0;
         if_ready <= 1'b0;
         if_inst  <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
      end else if (rdy) begin
         if_ready <= 1'b0;
         case (state)
            IDLE: begin
               if (if_valid && !clear) begin
                  if (hit) begin
                     if_inst  <= data[if_idx];
                     if_ready <= 1'b1;
                  end else begin
                     mem_addr <= {if_addr[31:2], 2'b00};
                     mem_req  <= 1'b1;
                     state    <= MISS;
                  end
               end
            end
            MISS: begin
               // A redirect outranks a completing refill; the returned word is dropped.
               if (clear) begin
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end else if (mem_done) begin
                  valid[req_idx] <= 1'b1;
                  if_inst        <= mem_data;
                  if_ready       <= 1'b1;
                  mem_req        <= 1'b0;
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios plus randomized fetch traffic checked
// against a word-address cache model held in plain arrays.
module tb_icache;

   localparam int IB    = 6;
   localparam int LINES = 1 << IB;

   logic        clk = 1'b0;
   logic        rst;
   logic        rdy;
   logic        if_valid;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_inst;
   logic        clear;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [31:0] mem_data;
   logic        mem_done;

   int n_vec = 0;
   int n_err = 0;

   // Reference model: each line remembers the full word address it holds.
   logic        mv [LINES];
   logic [29:0] mw [LINES];
   logic [31:0] md [LINES];

   icache #(.INDEX_BITS(IB)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .if_valid(if_valid), .if_addr(if_addr),
      .if_ready(if_ready), .if_inst(if_inst), .clear(clear), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_data(mem_data), .mem_done(mem_done)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic model_clear();
      for (int i = 0; i < LINES; i++) mv[i] = 1'b0;
   endtask

   // clr_mode: 0 = normal refill, 1 = clear instead of done, 2 = clear with done.
   task automatic fetch(input logic [31:0] addr, input int lat, input logic [31:0] word,
                        input int clr_mode);
      int idx;
      logic hit;
      idx = int'(addr[IB+1:2]);
      hit = mv[idx] && (mw[idx] == addr[31:2]);
      if_valid = 1'b1;
      if_addr  = addr;
      step();
      if_valid = 1'b0;
      if_addr  = $urandom;
      if (hit) begin
         n_vec++;
         if ({if_ready, mem_req, if_inst} !== {1'b1, 1'b0, md[idx]}) begin
            n_err++;
            $display("FAIL hit a=%h: ready=%b req=%b inst=%h, want 1 0 %h",
                     addr, if_ready, mem_req, if_inst, md[idx]);
         end
      end else begin
         n_vec++;
         if ({mem_req, if_ready, mem_addr} !== {1'b1, 1'b0, addr[31:2], 2'b00}) begin
            n_err++;
            $display("FAIL miss_issue a=%h: req=%b ready=%b maddr=%h, want 1 0 %h",
                     addr, mem_req, if_ready, mem_addr, {addr[31:2], 2'b00});
         end
         for (int k = 0; k < lat; k++) begin
            if_valid = $urandom_range(0, 1);
            mem_done = 1'b0;
            step();
            n_vec++;
            if ({mem_req, if_ready, mem_addr} !== {1'b1, 1'b0, addr[31:2], 2'b00}) begin
               n_err++;
               $display("FAIL miss_wait a=%h: req=%b ready=%b maddr=%h, want held",
                        addr, mem_req, if_ready, mem_addr);
            end
         end
         if_valid = 1'b0;
         mem_data = word;
         mem_done = (clr_mode != 1);
         clear    = (clr_mode != 0);
         step();
         mem_done = 1'b0;
         clear    = 1'b0;
         mem_data = $urandom;
         n_vec++;
         if (clr_mode != 0) begin
            if ({if_ready, mem_req} !== 2'b00) begin
               n_err++;
               $display("FAIL clear_miss a=%h: ready=%b req=%b, want 0 0",
                        addr, if_ready, mem_req);
            end
         end else begin
            if ({if_ready, mem_req, if_inst} !== {1'b1, 1'b0, word}) begin
               n_err++;
               $display("FAIL refill a=%h: ready=%b req=%b inst=%h, want 1 0 %h",
                        addr, if_ready, mem_req, if_inst, word);
            end
            mv[idx] = 1'b1;
            mw[idx] = addr[31:2];
            md[idx] = word;
         end
      end
   endtask

   task automatic test_reset();
      n_vec++;
      if ({if_ready, mem_req, if_inst, mem_addr} !== 66'd0) begin
         n_err++;
         $display("FAIL reset: ready=%b req=%b inst=%h maddr=%h, want all 0",
                  if_ready, mem_req, if_inst, mem_addr);
      end
      rst = 1'b1;
      step();
   endtask

   task automatic test_miss_fill();
      fetch(32'h0000_0000, 4, 32'h0000_0013, 0);
   endtask

   task automatic test_hit();
      fetch(32'h0000_0002, 0, 32'h0, 0);
      mem_done = 1'b1;
      mem_data = 32'hFFFF_0000;
      step();
      mem_done = 1'b0;
      n_vec++;
      if ({if_ready, mem_req} !== 2'b00) begin
         n_err++;
         $display("FAIL idle_done: ready=%b req=%b, want 0 0", if_ready, mem_req);
      end
      fetch(32'h0000_0001, 0, 32'h0, 0);
   endtask

   task automatic test_conflict();
      fetch(32'h0000_0100, 2, 32'hBBBB_0002, 0);
      fetch(32'h0000_0000, 1, 32'hAAAA_0001, 0);
      fetch(32'h0000_0000, 0, 32'h0, 0);
   endtask

   task automatic test_clear_miss();
      fetch(32'h0000_0200, 2, 32'hDEAD_0001, 1);
      fetch(32'h0000_0200, 1, 32'h1234_5678, 0);
   endtask

   task automatic test_clear_done();
      fetch(32'h0000_0304, 0, 32'hDEAD_0002, 2);
      fetch(32'h0000_0304, 2, 32'h8765_4321, 0);
   endtask

   task automatic test_rdy_hold();
      fetch(32'h0000_0044, 1, 32'h0C0F_FEE0, 0);
      fetch(32'h0000_0044, 0, 32'h0, 0);
      rdy      = 1'b0;
      if_valid = 1'b1;
      if_addr  = 32'h0000_0500;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if ({if_ready, mem_req, if_inst} !== {1'b1, 1'b0, 32'h0C0F_FEE0}) begin
            n_err++;
            $display("FAIL rdy_hold_ready: ready=%b req=%b inst=%h, want 1 0 0c0ffee0",
                     if_ready, mem_req, if_inst);
         end
      end
      rdy      = 1'b1;
      if_valid = 1'b0;
      step();
      n_vec++;
      if ({if_ready, mem_req} !== 2'b00) begin
         n_err++;
         $display("FAIL rdy_resume1: ready=%b req=%b, want 0 0", if_ready, mem_req);
      end
      if_valid = 1'b1;
      if_addr  = 32'h0000_0504;
      step();
      if_valid = 1'b0;
      rdy      = 1'b0;
      mem_done = 1'b1;
      mem_data = 32'h5A5A_A5A5;
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if ({mem_req, if_ready, mem_addr} !== {1'b1, 1'b0, 32'h0000_0504}) begin
            n_err++;
            $display("FAIL rdy_hold_req: req=%b ready=%b maddr=%h, want 1 0 00000504",
                     mem_req, if_ready, mem_addr);
         end
      end
      rdy = 1'b1;
      step();
      mem_done = 1'b0;
      n_vec++;
      if ({if_ready, mem_req, if_inst} !== {1'b1, 1'b0, 32'h5A5A_A5A5}) begin
         n_err++;
         $display("FAIL rdy_resume2: ready=%b req=%b inst=%h, want 1 0 5a5aa5a5",
                  if_ready, mem_req, if_inst);
      end
      mv[1] = 1'b1;
      mw[1] = 30'h0000_0504 >> 2;
      md[1] = 32'h5A5A_A5A5;
      fetch(32'h0000_0504, 0, 32'h0, 0);
   endtask

   task automatic test_back_to_back();
      logic [31:0] a;
      for (int k = 0; k < 4; k++) fetch(32'h80 + 32'(k * 4), k, $urandom, 0);
      for (int k = 0; k < 4; k++) begin
         a        = 32'h80 + 32'(k * 4);
         if_valid = 1'b1;
         if_addr  = a;
         step();
         n_vec++;
         if ({if_ready, mem_req, if_inst} !== {1'b1, 1'b0, md[32 + k]}) begin
            n_err++;
            $display("FAIL b2b a=%h: ready=%b req=%b inst=%h, want 1 0 %h",
                     a, if_ready, mem_req, if_inst, md[32 + k]);
         end
      end
      if_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid_miss();
      if_valid = 1'b1;
      if_addr  = 32'h0000_0090;
      step();
      if_valid = 1'b0;
      #2 rst = 1'b0;
      #1;
      n_vec++;
      if ({mem_req, if_ready, mem_addr} !== 34'd0) begin
         n_err++;
         $display("FAIL reset_mid_miss: req=%b ready=%b maddr=%h, want 0 0 0",
                  mem_req, if_ready, mem_addr);
      end
      step();
      rst = 1'b1;
      model_clear();
      step();
      fetch(32'h0000_0080, 1, 32'hCAFE_0080, 0);
   endtask

   task automatic test_random();
      logic [31:0] a;
      int r;
      for (int it = 0; it < 300; it++) begin
         a = ($urandom_range(0, 3) * 32'h0040_0100) | (32'($urandom_range(0, 7)) << 2)
             | 32'($urandom_range(0, 3));
         r = $urandom_range(0, 9);
         fetch(a, $urandom_range(0, 3), $urandom, (r == 0) ? 1 : (r == 1) ? 2 : 0);
         if ($urandom_range(0, 3) == 0) step();
      end
   endtask

   initial begin
      rst      = 1'b0;
      rdy      = 1'b1;
      if_valid = 1'b0;
      if_addr  = '0;
      clear    = 1'b0;
      mem_data = '0;
      mem_done = 1'b0;
      model_clear();
      step();
      step();
      test_reset();
      test_miss_fill();
      test_hit();
      test_conflict();
      test_clear_miss();
      test_clear_done();
      test_rdy_hold();
      test_back_to_back();
      test_reset_mid_miss();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
